// File: rtl/mio_bus_responder_pkg.sv
// Address map, region select and FSM state types shared by the MIO responder.
package mio_map_pkg;

  localparam logic [31:0] LED_ADDR = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR  = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR = 32'hF000_0004;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_LED,
    REG_SW,
    REG_CNT,
    REG_NONE
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Decode a word address (byte address bits [31:2]); RAM needs all bits above the
  // RAM index to be zero.
  function automatic region_e decode_region(input logic [29:0] waddr,
                                            input int unsigned ram_aw);
    if ((waddr >> ram_aw) == 30'd0)  return REG_RAM;
    if (waddr == LED_ADDR[31:2])     return REG_LED;
    if (waddr == SW_ADDR[31:2])      return REG_SW;
    if (waddr == CNT_ADDR[31:2])     return REG_CNT;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// CPU <-> responder request/response signals of the MIO bus.
interface mio_bus_responder_if;
  logic        CPU_MIO;
  logic        MemRW;
  logic [31:0] Addr_in;
  logic [31:0] Data_wr;
  logic [31:0] Data_rd;
  logic        MIO_ready;

  modport master (
    output CPU_MIO, MemRW, Addr_in, Data_wr,
    input  Data_rd, MIO_ready
  );

  modport slave (
    input  CPU_MIO, MemRW, Addr_in, Data_wr,
    output Data_rd, MIO_ready
  );
endinterface

// File: rtl/mio_bus_responder_ram.sv
// Data RAM: synchronous single write port, asynchronous read of the same word.
module mio_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus responder: latches a CPU request, waits WAIT_CYCLES, then completes it
// against RAM, LED, switch or timer registers and pulses MIO_ready.
//
// state   | meaning
// IDLE    | waiting for CPU_MIO; request latched on the accepting edge
// WAIT    | counting wait states down in wcnt
// DONE    | completion edge follows: commit write / capture read, raise MIO_ready
module mio_bus_responder
  import mio_map_pkg::*;
#(
  parameter int unsigned RAM_AW      = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] CNT_RST     = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  mio_bus_responder_if.slave    bus,
  input  logic [15:0]           sw_in,
  output logic [15:0]           led_out,
  output logic                  bus_err
);

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        latch;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] data_rd_q;
  logic        ready_q;
  logic [15:0] led_q;
  logic [31:0] cnt_q;
  logic        err_q;

  region_e     region;
  logic        commit;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] rd_val;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus.Addr_in[1:0];

  // Next-state logic; the DONE state marks the edge on which the access completes.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.CPU_MIO) begin
          latch   = 1'b1;
          wcnt_d  = WC;
          state_d = (WC == 4'd0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Request capture; later bus activity is ignored until IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (latch) begin
      addr_q  <= bus.Addr_in[31:2];
      wdata_q <= bus.Data_wr;
      we_q    <= bus.MemRW;
    end
  end

  assign region = decode_region(addr_q, RAM_AW);
  assign commit = (state_q == ST_DONE);
  assign ram_we = commit && we_q && (region == REG_RAM);

  mio_ram #(.AW(RAM_AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (addr_q[RAM_AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Read data mux; the timer returns its value before this edge's update.
  always_comb begin
    rd_val = 32'h0;
    case (region)
      REG_RAM: rd_val = ram_rdata;
      REG_LED: rd_val = {16'h0, led_q};
      REG_SW:  rd_val = {16'h0, sw_in};
      REG_CNT: rd_val = cnt_q;
      default: rd_val = 32'h0;
    endcase
  end

  // Completion: read capture, ready pulse, LED write and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_rd_q <= 32'h0;
      ready_q   <= 1'b0;
      led_q     <= 16'h0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= commit;
      if (commit && !we_q) data_rd_q <= rd_val;
      if (commit && we_q && (region == REG_LED)) led_q <= wdata_q[15:0];
      if (commit && (region == REG_NONE)) err_q <= 1'b1;
    end
  end

  // Free-running timer; a completing write overrides the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= CNT_RST;
    end else if (commit && we_q && (region == REG_CNT)) begin
      cnt_q <= wdata_q;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.Data_rd   = data_rd_q;
  assign bus.MIO_ready = ready_q;
  assign led_out       = led_q;
  assign bus_err       = err_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: three instances with 1, 0 and 3 wait states.
module tb_mio_bus_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [15:0] sw1, sw0, sw3;
  logic [15:0] led1, led0, led3;
  logic        err1, err0, err3;

  mio_bus_responder_if bus1();
  mio_bus_responder_if bus0();
  mio_bus_responder_if bus3();

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(1), .CNT_RST(32'h0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .sw_in(sw1), .led_out(led1), .bus_err(err1));
  mio_bus_responder #(.RAM_AW(4), .WAIT_CYCLES(0), .CNT_RST(32'h0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .sw_in(sw0), .led_out(led0), .bus_err(err0));
  mio_bus_responder #(.RAM_AW(4), .WAIT_CYCLES(3), .CNT_RST(32'h0)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .sw_in(sw3), .led_out(led3), .bus_err(err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int which, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    case (which)
      0: begin bus0.CPU_MIO = req; bus0.MemRW = we; bus0.Addr_in = a; bus0.Data_wr = d; end
      3: begin bus3.CPU_MIO = req; bus3.MemRW = we; bus3.Addr_in = a; bus3.Data_wr = d; end
      default: begin bus1.CPU_MIO = req; bus1.MemRW = we; bus1.Addr_in = a; bus1.Data_wr = d; end
    endcase
  endtask

  function automatic logic rdy(input int which);
    case (which)
      0: return bus0.MIO_ready;
      3: return bus3.MIO_ready;
      default: return bus1.MIO_ready;
    endcase
  endfunction

  function automatic logic [31:0] rdat(input int which);
    case (which)
      0: return bus0.Data_rd;
      3: return bus3.Data_rd;
      default: return bus1.Data_rd;
    endcase
  endfunction

  // One access; lat = posedges from the accepting edge to MIO_ready (0 = timed out).
  task automatic access(input int which, input logic we, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
    @(negedge clk);
    drive(which, 1'b1, we, a, d);
    @(posedge clk); #1;
    drive(which, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rdy(which)) begin
        lat = i;
        break;
      end
    end
    rd = rdat(which);
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (bus1.MIO_ready !== 1'b0 || bus1.Data_rd !== 32'h0 || led1 !== 16'h0 || err1 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: ready=%b rd=%h led=%h err=%b, want 0/0/0/0",
               bus1.MIO_ready, bus1.Data_rd, led1, err1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] rd;
    int lat;
    access(1, 1'b1, 32'h0000_0010, 32'h1234_5678, rd, lat);
    n_checks++;
    if (lat !== 2) begin n_errors++; $display("FAIL ram_wr_latency: got %0d want 2", lat); end
    n_checks++;
    if (rd !== 32'h0) begin n_errors++; $display("FAIL ram_wr_rd_unchanged: got %h want 0", rd); end
    access(1, 1'b0, 32'h0000_0010, 32'h0, rd, lat);
    n_checks++;
    if (lat !== 2) begin n_errors++; $display("FAIL ram_rd_latency: got %0d want 2", lat); end
    n_checks++;
    if (rd !== 32'h1234_5678) begin n_errors++; $display("FAIL ram_rd_data: got %h want 12345678", rd); end
  endtask

  task automatic test_io();
    logic [31:0] rd;
    int lat;
    access(1, 1'b1, 32'hE000_0000, 32'h0000_A5A5, rd, lat);
    n_checks++;
    if (led1 !== 16'hA5A5 || lat !== 2) begin
      n_errors++; $display("FAIL led_write: led=%h lat=%0d want a5a5/2", led1, lat);
    end
    n_checks++;
    if (rd !== 32'h1234_5678) begin n_errors++; $display("FAIL led_wr_keeps_rd: got %h want 12345678", rd); end
    access(1, 1'b0, 32'hE000_0000, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0000_A5A5) begin n_errors++; $display("FAIL led_read: got %h want 0000a5a5", rd); end
    sw1 = 16'h00FF;
    access(1, 1'b0, 32'hF000_0000, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0000_00FF) begin n_errors++; $display("FAIL sw_read: got %h want 000000ff", rd); end
    access(1, 1'b1, 32'hF000_0000, 32'h0000_1111, rd, lat);
    access(1, 1'b0, 32'hF000_0000, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0000_00FF || err1 !== 1'b0) begin
      n_errors++; $display("FAIL sw_write_ignored: rd=%h err=%b want 000000ff/0", rd, err1);
    end
  endtask

  task automatic test_counter();
    logic [31:0] rd;
    int lat;
    access(1, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, lat);
    access(1, 1'b0, 32'hF000_0004, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0) begin n_errors++; $display("FAIL cnt_wrap_read: got %h want 00000000", rd); end
    access(1, 1'b0, 32'hF000_0004, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h3) begin n_errors++; $display("FAIL cnt_after_wrap: got %h want 00000003", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    int lat;
    access(1, 1'b1, 32'h0000_0000, 32'h0000_0A0A, rd, lat);
    access(1, 1'b0, 32'h1000_0000, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0 || lat !== 2 || err1 !== 1'b1) begin
      n_errors++; $display("FAIL unmapped_read: rd=%h lat=%0d err=%b want 0/2/1", rd, lat, err1);
    end
    access(1, 1'b1, 32'h0000_1000, 32'h0000_0BAD, rd, lat);
    access(1, 1'b0, 32'h0000_0000, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h0000_0A0A || err1 !== 1'b1) begin
      n_errors++; $display("FAIL unmapped_write_sticky: rd=%h err=%b want 00000a0a/1", rd, err1);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    int lat;
    logic seen;
    access(1, 1'b1, 32'h0000_0020, 32'hCAFE_0008, rd, lat);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus1.MIO_ready !== 1'b0 || bus1.Data_rd !== 32'h0 || led1 !== 16'h0 || err1 !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_outputs: ready=%b rd=%h led=%h err=%b want 0/0/0/0",
               bus1.MIO_ready, bus1.Data_rd, led1, err1);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus1.MIO_ready) seen = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus1.MIO_ready) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL abort_no_ready: ready seen=%b want 0", seen); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    access(1, 1'b0, 32'hF000_0004, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h3 || lat !== 2) begin
      n_errors++; $display("FAIL cnt_after_reset: rd=%h lat=%0d want 00000003/2", rd, lat);
    end
    access(1, 1'b0, 32'h0000_0020, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'hCAFE_0008) begin n_errors++; $display("FAIL ram_after_abort: got %h want cafe0008", rd); end
  endtask

  task automatic test_wait_sweep();
    logic [31:0] rd;
    int lat;
    access(0, 1'b1, 32'h0000_0004, 32'h0000_0011, rd, lat);
    n_checks++;
    if (lat !== 1) begin n_errors++; $display("FAIL wait0_latency: got %0d want 1", lat); end
    access(0, 1'b0, 32'h0000_0004, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h11 || lat !== 1) begin
      n_errors++; $display("FAIL wait0_read: rd=%h lat=%0d want 00000011/1", rd, lat);
    end
    access(3, 1'b1, 32'h0000_0008, 32'h0000_0033, rd, lat);
    n_checks++;
    if (lat !== 4) begin n_errors++; $display("FAIL wait3_latency: got %0d want 4", lat); end
    access(3, 1'b0, 32'h0000_0008, 32'h0, rd, lat);
    n_checks++;
    if (rd !== 32'h33 || lat !== 4) begin
      n_errors++; $display("FAIL wait3_read: rd=%h lat=%0d want 00000033/4", rd, lat);
    end
  endtask

  // Hold CPU_MIO high for 10 edges and record where MIO_ready is seen.
  task automatic b2b(input int which, input logic [31:0] a, input logic [9:0] exp_mask,
                     input logic [31:0] exp_rd, input string name);
    logic [9:0] mask;
    @(negedge clk);
    drive(which, 1'b1, 1'b0, a, 32'h0);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      mask[i] = rdy(which);
    end
    drive(which, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (mask !== exp_mask || rdat(which) !== exp_rd) begin
      n_errors++;
      $display("FAIL %s: ready pattern=%b rd=%h want %b/%h", name, mask, rdat(which), exp_mask, exp_rd);
    end
  endtask

  task automatic test_back_to_back();
    b2b(1, 32'h0000_0020, 10'b00_1001_0010, 32'hCAFE_0008, "b2b_wait1");
    b2b(0, 32'h0000_0004, 10'b01_0101_0101, 32'h0000_0011, "b2b_wait0");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    sw1 = 16'h0; sw0 = 16'h0; sw3 = 16'h0;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_ram();
    test_io();
    test_counter();
    test_unmapped();
    test_async_reset();
    test_wait_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
